inst_sequencer: RTL

//  Upstream feeder for the multicycle processor core: holds a small program in
//  an internal instruction RAM and issues it word-by-word on DIN using the core's
//  Run/Done handshake. Program is loaded through a write port while idle, then

---
 rtl/inst_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/inst_sequencer.sv
// Instruction sequencer: stores a short program in a local RAM and issues it word by
// word to the core over the Run/Done handshake. Optional single-step mode: INST_SEQUENCER_SINGLE_STEP_EN.
module inst_sequencer #(
    parameter int AW      = 4,
    parameter int TIMEOUT = 8
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          WrEn,
    input  logic [AW-1:0] WrAddr,
    input  logic [15:0]   WrData,
    input  logic          Go,
    input  logic [AW:0]   Length,
    input  logic          Done,
`ifdef INST_SEQUENCER_SINGLE_STEP_EN
    input  logic          Step,
`endif
    output logic [15:0]   DIN,
    output logic          Run,
    output logic          Busy,
    output logic          Finished,
    output logic          Error,
    output logic [AW-1:0] PC,
    output logic [2:0]    DbgState
);

    localparam int DEPTH = 2 ** AW;
    localparam int WDW   = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_ERROR = 3'd4
`ifdef INST_SEQUENCER_SINGLE_STEP_EN
        , S_PAUSE = 3'd5
`endif
    } state_t;

    // Handshake: Run is high for exactly the ISSUE cycle with DIN already stable;
    // the core acknowledges with Done, which only counts while in WAIT.
    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW:0]     rem_q, rem_d;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic [15:0]     din_q, din_d;
    logic            err_q, err_d;
    logic            fin_q, fin_d;
    logic [15:0]     mem [DEPTH];
    logic            accept_cmd;

    assign accept_cmd = (state_q == S_IDLE) || (state_q == S_ERROR);

    // Program RAM is not reset so a loaded program survives a core reset.
    always_ff @(posedge Clock) begin
        if (WrEn && accept_cmd) begin
            mem[WrAddr] <= WrData;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            rem_q   <= '0;
            wdog_q  <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rem_q   <= rem_d;
            wdog_q  <= wdog_d;
            din_q   <= din_d;
            err_q   <= err_d;
            fin_q   <= fin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rem_d   = rem_q;
        wdog_d  = wdog_q;
        din_d   = din_q;
        err_d   = err_q;
        fin_d   = 1'b0;
        case (state_q)
            S_IDLE, S_ERROR: begin
                if (Go) begin
                    err_d = 1'b0;
                    if (Length != '0) begin
                        state_d = S_READ;
                        pc_d    = '0;
                        rem_d   = Length;
                    end else begin
                        state_d = S_IDLE;
                        fin_d   = 1'b1;
                    end
                end
            end
            S_READ: begin
                // DIN doubles as the RAM read register.
                din_d   = mem[pc_q];
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                wdog_d  = '0;
            end
            S_WAIT: begin
                if (Done) begin
                    rem_d = rem_q - (AW+1)'(1);
                    pc_d  = pc_q + AW'(1);
                    if (rem_q == (AW+1)'(1)) begin
                        state_d = S_IDLE;
                        fin_d   = 1'b1;
                    end else begin
`ifdef INST_SEQUENCER_SINGLE_STEP_EN
                        state_d = S_PAUSE;
`else
                        state_d = S_READ;
`endif
                    end
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
`ifdef INST_SEQUENCER_SINGLE_STEP_EN
            S_PAUSE: begin
                if (Step) begin
                    state_d = S_READ;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign Run      = (state_q == S_ISSUE);
`ifdef INST_SEQUENCER_SINGLE_STEP_EN
    assign Busy     = (state_q == S_READ) || (state_q == S_ISSUE) ||
                      (state_q == S_WAIT) || (state_q == S_PAUSE);
`else
    assign Busy     = (state_q == S_READ) || (state_q == S_ISSUE) ||
                      (state_q == S_WAIT);
`endif
    assign DIN      = din_q;
    assign Finished = fin_q;
    assign Error    = err_q;
    assign PC       = pc_q;
    assign DbgState = state_q;

endmodule
